// File: rtl/timer_setpoint_ctrl.sv
// -----------------------------------------------------------------------------
// timer_setpoint_ctrl
//
// Front-panel stage of the egg timer. It turns four raw push buttons into a
// 12-bit seconds setpoint and a one-cycle start request for the countdown
// block. The setpoint is kept between runs and is locked while a countdown is
// in progress.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   btn_sec    in   raw button, +1 s (auto-repeats while held)
//   btn_min    in   raw button, +60 s (auto-repeats while held)
//   btn_clear  in   raw button, setpoint <= 0
//   btn_start  in   raw button, launch the countdown
//   timer_done in   one-cycle done pulse from the countdown block
//   load_out   out  setpoint in seconds (countdown load value and display)
//   start      out  one-cycle start request
//   running    out  high while a countdown is in progress
// -----------------------------------------------------------------------------
module timer_setpoint_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int MAX_SET         = 3599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_sec,
  input  logic        btn_min,
  input  logic        btn_clear,
  input  logic        btn_start,
  input  logic        timer_done,
  output logic [11:0] load_out,
  output logic        start,
  output logic        running
);

  localparam int B_SEC   = 0;
  localparam int B_MIN   = 1;
  localparam int B_CLEAR = 2;
  localparam int B_START = 3;

  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    ST_EDIT    = 2'b01,
    ST_RUNNING = 2'b10
  } state_e;

  logic [3:0] raw;
  logic [3:0] press;   // one-cycle press events
  logic [1:0] rpt;     // one-cycle auto-repeat increments (sec, min)

  assign raw = {btn_start, btn_clear, btn_min, btn_sec};

  // Sync pipelines hold reset values for two cycles after rst falls; a button
  // may only arm once its synchronised level is real and seen low.
  logic [1:0] vld_q;

  // NOTE: every button flop and counter resets asynchronously on rst, so a
  // partly debounced press cannot survive a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[0], 1'b1};
  end

  // ---------------------------------------------------------------------------
  // Per-button conditioning: synchronise, debounce, edge-detect, auto-repeat
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic          s1_q, s2_q;
    logic          db_q, db_prev_q;
    logic          arm_q;
    logic          press_q;
    logic [DW-1:0] deb_cnt_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        arm_q     <= 1'b0;
        press_q   <= 1'b0;
        deb_cnt_q <= '0;
      end else begin
        s1_q      <= raw[i];
        s2_q      <= s1_q;
        db_prev_q <= db_q;
        press_q   <= db_q & ~db_prev_q & arm_q;

        // A button held through reset stays disarmed until it is released,
        // so it cannot produce a stale press or auto-repeat.
        if (vld_q[1] && !s2_q && !db_q) arm_q <= 1'b1;

        // Count consecutive samples that disagree with the debounced level.
        if (s2_q == db_q) begin
          deb_cnt_q <= '0;
        end else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_q      <= s2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end
    end

    assign press[i] = press_q;

    if (i < 2) begin : g_rpt
      logic          first_q;
      logic          rpt_q;
      logic [RW-1:0] rpt_cnt_q;
      logic          level;

      assign level = db_q & arm_q;

      // The counter starts with the level, one cycle before the press event,
      // so the first repeat lands REPEAT_DELAY cycles after the press and the
      // later ones every REPEAT_PERIOD cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          first_q   <= 1'b1;
          rpt_q     <= 1'b0;
          rpt_cnt_q <= '0;
        end else if (!level) begin
          first_q   <= 1'b1;
          rpt_q     <= 1'b0;
          rpt_cnt_q <= '0;
        end else begin
          rpt_q <= 1'b0;
          if (first_q && rpt_cnt_q == RW'(REPEAT_DELAY)) begin
            rpt_q     <= 1'b1;
            first_q   <= 1'b0;
            rpt_cnt_q <= RW'(1);
          end else if (!first_q && rpt_cnt_q == RW'(REPEAT_PERIOD)) begin
            rpt_q     <= 1'b1;
            rpt_cnt_q <= RW'(1);
          end else begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
          end
        end
      end

      assign rpt[i] = rpt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Setpoint / run control
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [11:0] load_q, load_d;
  logic        start_q, start_d;
  logic        running_q, running_d;
  logic        sec_inc, min_inc;
  logic [12:0] sum;

  assign sec_inc = press[B_SEC] | rpt[B_SEC];
  assign min_inc = press[B_MIN] | rpt[B_MIN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EDIT;
      load_q    <= '0;
      start_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      start_q   <= start_d;
      running_q <= running_d;
    end
  end

  // NOTE: all outputs of this block get a default before the case so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    start_d   = 1'b0;
    running_d = running_q;
    sum       = {1'b0, load_q} + (sec_inc ? 13'd1 : 13'd0) + (min_inc ? 13'd60 : 13'd0);

    case (state_q)
      ST_EDIT: begin
        running_d = 1'b0;
        if (press[B_CLEAR]) begin
          load_d = '0;
        end else if (press[B_START] && load_q != '0) begin
          start_d   = 1'b1;
          running_d = 1'b1;
          state_d   = ST_RUNNING;
        end else if (sum > 13'(MAX_SET)) begin
          load_d = 12'(MAX_SET);
        end else begin
          load_d = sum[11:0];
        end
      end
      ST_RUNNING: begin
        // Ignoring done during the start cycle keeps start and done apart.
        if (timer_done && !start_q) begin
          running_d = 1'b0;
          state_d   = ST_EDIT;
        end
      end
      default: begin
        running_d = 1'b0;
        state_d   = ST_EDIT;
      end
    endcase
  end

  assign load_out = load_q;
  assign start    = start_q;
  assign running  = running_q;

endmodule

// File: tb/tb_timer_setpoint_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for timer_setpoint_ctrl with short debounce/repeat timing.
// Every setpoint change the bench expects is pushed to a queue as stimulus is
// driven; a monitor pops and compares whenever load_out changes.
// -----------------------------------------------------------------------------
module tb_timer_setpoint_ctrl;

  localparam int DEB     = 4;
  localparam int RDLY    = 20;
  localparam int RPER    = 5;
  localparam int MAX_SET = 3599;

  localparam logic [3:0] SEC = 4'b0001;
  localparam logic [3:0] MIN = 4'b0010;
  localparam logic [3:0] CLR = 4'b0100;
  localparam logic [3:0] STA = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn = '0;
  logic        timer_done = 1'b0;
  logic [11:0] load_out;
  logic        start;
  logic        running;

  timer_setpoint_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER),
    .MAX_SET        (MAX_SET)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_sec   (btn[0]),
    .btn_min   (btn[1]),
    .btn_clear (btn[2]),
    .btn_start (btn[3]),
    .timer_done(timer_done),
    .load_out  (load_out),
    .start     (start),
    .running   (running)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  int          model_load = 0;
  logic [11:0] last_load = '0;
  logic        prev_start = 1'b0;
  int          start_cnt = 0;
  int          mon_exp;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model of an EDIT-state edit; queues the new setpoint if it changes.
  task automatic expect_edit(input logic [3:0] mask);
    int nv;
    if (mask[2]) begin
      nv = 0;
    end else begin
      nv = model_load + (mask[0] ? 1 : 0) + (mask[1] ? 60 : 0);
      if (nv > MAX_SET) nv = MAX_SET;
    end
    if (nv != model_load) exp_q.push_back(12'(nv));
    model_load = nv;
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    btn = btn | mask;
    repeat (hold) @(negedge clk);
    btn = btn & ~mask;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_done();
    timer_done = 1'b1;
    @(negedge clk);
    timer_done = 1'b0;
  endtask

  // Monitor: scoreboard on load_out changes, plus start-pulse width/count.
  always @(negedge clk) begin
    if (!rst) begin
      if (start) begin
        start_cnt++;
        check("start_one_cycle", int'(prev_start), 0);
      end
      prev_start = start;
      if (load_out !== last_load) begin
        if (exp_q.size() != 0) mon_exp = int'(exp_q.pop_front());
        else                   mon_exp = int'(last_load);
        check("load_seq", int'(load_out), mon_exp);
        last_load = load_out;
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int s0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_load", int'(load_out), 0);
    check("rst_start", int'(start), 0);
    check("rst_running", int'(running), 0);
    #3 rst = 1'b0;
    repeat (5) @(negedge clk);

    // ---------------- debounce ----------------
    expect_edit(SEC);
    for (int i = 0; i < 10; i++) begin
      btn[0] = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn[0] = 1'b1;
    lat = -1;
    // Press event 2 + DEB + 1 = 7 edges after the stable edge; the setpoint
    // register shows it one edge later.
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (load_out != 12'd0 && lat < 0) lat = k;
    end
    check("deb_latency", lat, 2 + DEB + 1 + 1);
    @(negedge clk);
    btn[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("deb_load", int'(load_out), 1);
    check("deb_sb_empty", exp_q.size(), 0);

    // ---------------- build 3500, then held min saturates ----------------
    expect_edit(CLR);
    press(CLR, 10);
    for (int i = 0; i < 58; i++) begin
      expect_edit(MIN);
      press(MIN, 10);
    end
    for (int i = 0; i < 20; i++) begin
      expect_edit(SEC);
      press(SEC, 10);
    end
    check("load_3500", int'(load_out), 3500);
    check("build_sb_empty", exp_q.size(), 0);

    expect_edit(MIN);   // 3560 at the press
    expect_edit(MIN);   // 3599 at the first repeat; later repeats change nothing
    press(MIN, 60);
    check("sat_load", int'(load_out), MAX_SET);
    check("sat_sb_empty", exp_q.size(), 0);

    // ---------------- simultaneous events ----------------
    expect_edit(CLR);
    press(CLR, 10);
    expect_edit(SEC | MIN);
    press(SEC | MIN, 10);
    check("sec_min_load", int'(load_out), 61);
    expect_edit(CLR | SEC);
    press(CLR | SEC, 10);
    check("clr_sec_load", int'(load_out), 0);
    check("simul_sb_empty", exp_q.size(), 0);

    // ---------------- start at zero ----------------
    s0 = start_cnt;
    press(STA, 10);
    check("start_zero_pulses", start_cnt - s0, 0);
    check("start_zero_running", int'(running), 0);

    // ---------------- start / run / done ----------------
    expect_edit(MIN);
    press(MIN, 10);
    for (int i = 0; i < 30; i++) begin
      expect_edit(SEC);
      press(SEC, 10);
    end
    check("load_90", int'(load_out), 90);
    s0 = start_cnt;
    press(STA, 10);
    check("run_start_pulses", start_cnt - s0, 1);
    check("run_running", int'(running), 1);
    press(SEC, 10);
    check("run_locked_load", int'(load_out), 90);
    check("run_still_running", int'(running), 1);
    pulse_done();
    check("done_running", int'(running), 0);
    check("done_load", int'(load_out), 90);
    repeat (3) @(negedge clk);
    pulse_done();
    check("done_in_edit_running", int'(running), 0);
    s0 = start_cnt;
    press(STA, 10);
    check("restart_pulses", start_cnt - s0, 1);
    check("restart_running", int'(running), 1);
    check("run_sb_empty", exp_q.size(), 0);

    // ---------------- async reset mid-run, mid-debounce ----------------
    btn[0] = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(12'd0);
    model_load = 0;
    #2 rst = 1'b1;
    #1;
    check("arst_load", int'(load_out), 0);
    check("arst_running", int'(running), 0);
    check("arst_start", int'(start), 0);
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    repeat (30) @(negedge clk);
    check("held_after_rst_load", int'(load_out), 0);
    btn[0] = 1'b0;
    repeat (12) @(negedge clk);
    expect_edit(SEC);
    press(SEC, 10);
    check("post_rst_press", int'(load_out), 1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
